// File: rtl/bd_downstream_ctrl_if.sv
// rtl/bd_downstream_ctrl_if.sv - host, generator and BD_out handshake bundle for bd_downstream_ctrl
interface bd_downstream_ctrl_if;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic [20:0] gen_data;
  logic        gen_valid;
  logic        gen_ready;
  logic [20:0] BD_out_data;
  logic        BD_out_valid;
  logic        BD_out_ready;

  modport master (
    output host_data, host_valid,
    input  host_ready,
    output gen_data, gen_valid,
    input  gen_ready,
    input  BD_out_data, BD_out_valid,
    output BD_out_ready
  );

  modport slave (
    input  host_data, host_valid,
    output host_ready,
    input  gen_data, gen_valid,
    output gen_ready,
    output BD_out_data, BD_out_valid,
    input  BD_out_ready
  );
endinterface

// File: rtl/bd_downstream_ctrl.sv
// rtl/bd_downstream_ctrl.sv - FPGA to Braindrop downstream controller: host decode, send arbitration, chip reset sequencing
module bd_downstream_ctrl #(
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bd_downstream_ctrl_if.slave  bus,
  output logic                 pReset,
  output logic                 sReset,
  output logic                 hold_active,
  output logic                 bad_op
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic {OWN_HOST, OWN_GEN} owner_t;

  owner_t          r_owner;
  logic [CW-1:0]   r_burst_cnt;
  logic            r_preset;
  logic            r_sreset;
  logic            r_hold_active;
  logic [20:0]     r_hold_data;
  logic            r_bad_op;
  logic            r_out_valid;
  logic [20:0]     r_out_data;

  logic [5:0]      w_op;
  logic            w_is_send;
  logic            w_gate;
  logic            w_load;
  logic            w_host_req;
  logic            w_gen_req;
  logic            w_owner_wins;
  logic            w_grant_gen;
  logic            w_take;
  logic            w_cfg_take;
  logic            w_unused;

  assign w_op      = bus.host_data[31:26];
  assign w_is_send = !w_op[5] && w_op[4];
  assign w_gate    = r_preset | r_sreset;
  assign w_load    = !r_out_valid | bus.BD_out_ready;
  assign w_unused  = ^bus.host_data[25:21];

  // Only send words compete for the output; config words bypass arbitration entirely.
  assign w_host_req   = bus.host_valid & w_is_send & !w_gate;
  assign w_gen_req    = bus.gen_valid & !w_gate;
  assign w_owner_wins = r_burst_cnt < BURST_MAX;

  always_comb begin
    w_grant_gen = w_gen_req;
    if (w_host_req && w_gen_req)
      w_grant_gen = (r_owner == OWN_GEN) ? w_owner_wins : !w_owner_wins;
  end

  assign w_take     = !reset & w_load & (w_host_req | w_gen_req);
  assign w_cfg_take = !reset & bus.host_valid & !w_is_send;

  assign bus.host_ready   = w_cfg_take | (w_take & !w_grant_gen);
  assign bus.gen_ready    = w_take & w_grant_gen;
  assign bus.BD_out_data  = r_out_data;
  assign bus.BD_out_valid = r_out_valid;
  assign pReset           = r_preset;
  assign sReset           = r_sreset;
  assign hold_active      = r_hold_active;
  assign bad_op           = r_bad_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner       <= OWN_HOST;
      r_burst_cnt   <= '0;
      r_preset      <= 1'b1;
      r_sreset      <= 1'b1;
      r_hold_active <= 1'b0;
      r_hold_data   <= '0;
      r_bad_op      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
    end else begin
      r_bad_op <= w_cfg_take && (w_op == 6'd0);
      if (w_cfg_take && !w_op[5]) begin
        if (w_op[3])
          r_preset <= 1'b0;
        else if (w_op[2])
          r_sreset <= 1'b0;
        else if (w_op[1]) begin
          r_hold_active <= 1'b1;
          r_hold_data   <= bus.host_data[20:0];
        end else if (w_op[0])
          r_hold_active <= 1'b0;
      end

      if (w_take) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_hold_active ? r_hold_data
                     : (w_grant_gen ? bus.gen_data : bus.host_data[20:0]);
        if (w_grant_gen == (r_owner == OWN_GEN)) begin
          if (r_burst_cnt != BURST_MAX)
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end else begin
          r_owner     <= w_grant_gen ? OWN_GEN : OWN_HOST;
          r_burst_cnt <= CW'(1);
        end
      end else if (bus.BD_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bd_downstream_ctrl.sv
// tb/tb_bd_downstream_ctrl.sv - self-checking bench for bd_downstream_ctrl
module tb_bd_downstream_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic pReset, sReset, hold_active, bad_op;
  int   n_assert = 0;
  int   n_fail = 0;

  bd_downstream_ctrl_if bif ();

  bd_downstream_ctrl #(.MAX_BURST(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bif),
    .pReset      (pReset),
    .sReset      (sReset),
    .hold_active (hold_active),
    .bad_op      (bad_op)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.host_valid   = 1'b0;
    bif.host_data    = '0;
    bif.gen_valid    = 1'b0;
    bif.gen_data     = '0;
    bif.BD_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic host_word(input logic [31:0] w);
    bit ok = 1'b0;
    bif.host_data  = w;
    bif.host_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = bif.host_ready;
      cyc();
    end
    bif.host_valid = 1'b0;
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL host_accept: word %h got no host_ready, required consumption within 20 cycles", w);
    end
  endtask

  task automatic release_resets();
    host_word(32'h2000_0000);
    host_word(32'h1000_0000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.host_valid   = 1'b1;
    bif.host_data    = 32'h2000_0000;
    bif.gen_valid    = 1'b1;
    bif.gen_data     = 21'h00_0001;
    bif.BD_out_ready = 1'b1;
    cyc();
    cyc();
    n_assert++;
    if ({bif.BD_out_valid, bif.BD_out_data, pReset, sReset, hold_active, bad_op} !== {1'b0, 21'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b d=%h p=%b s=%b h=%b b=%b required v=0 d=0 p=1 s=1 h=0 b=0",
               bif.BD_out_valid, bif.BD_out_data, pReset, sReset, hold_active, bad_op);
    end
    #1;
    n_assert++;
    if ({bif.host_ready, bif.gen_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got host_ready=%b gen_ready=%b required 0 0", bif.host_ready, bif.gen_ready);
    end
    idle_inputs();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset_release();
    host_word(32'h2000_0000);
    n_assert++;
    if ({pReset, sReset, bif.BD_out_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL preset_release: got p=%b s=%b v=%b required p=0 s=1 v=0", pReset, sReset, bif.BD_out_valid);
    end
    host_word(32'h1000_0000);
    n_assert++;
    if ({pReset, sReset, bif.BD_out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL sreset_release: got p=%b s=%b v=%b required 0 0 0", pReset, sReset, bif.BD_out_valid);
    end
  endtask

  task automatic test_gating();
    do_reset();
    bif.BD_out_ready = 1'b1;
    bif.host_valid   = 1'b1;
    bif.host_data    = 32'h4013_3333;
    bif.gen_valid    = 1'b1;
    bif.gen_data     = 21'h0A_AAAA;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_assert++;
      if ({bif.host_ready, bif.gen_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL gate_ready: got host_ready=%b gen_ready=%b required 0 0", bif.host_ready, bif.gen_ready);
      end
      cyc();
      n_assert++;
      if (bif.BD_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gate_no_output: got BD_out_valid=%b required 0", bif.BD_out_valid);
      end
    end
    bif.host_valid = 1'b0;
    host_word(32'h2000_0000);
    bif.host_data  = 32'h1000_0000;
    bif.host_valid = 1'b1;
    #1;
    n_assert++;
    if ({bif.host_ready, bif.gen_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL gate_same_cycle: got host_ready=%b gen_ready=%b required 1 0", bif.host_ready, bif.gen_ready);
    end
    cyc();
    bif.host_valid = 1'b0;
    #1;
    n_assert++;
    if (bif.gen_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_open: got gen_ready=%b required 1", bif.gen_ready);
    end
    cyc();
    bif.gen_valid = 1'b0;
    n_assert++;
    if ({bif.BD_out_valid, bif.BD_out_data} !== {1'b1, 21'h0A_AAAA}) begin
      n_fail++;
      $display("FAIL gate_gen_out: got v=%b d=%h required v=1 d=0aaaaa", bif.BD_out_valid, bif.BD_out_data);
    end
    host_word(32'h4013_3333);
    n_assert++;
    if ({bif.BD_out_valid, bif.BD_out_data} !== {1'b1, 21'h13_3333}) begin
      n_fail++;
      $display("FAIL gate_host_out: got v=%b d=%h required v=1 d=133333", bif.BD_out_valid, bif.BD_out_data);
    end
  endtask

  task automatic test_hold();
    bif.BD_out_ready = 1'b1;
    host_word(32'h081F_FFFF);
    n_assert++;
    if (hold_active !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_on: got hold_active=%b required 1", hold_active);
    end
    host_word(32'h4013_3333);
    n_assert++;
    if ({bif.BD_out_valid, bif.BD_out_data} !== {1'b1, 21'h1F_FFFF}) begin
      n_fail++;
      $display("FAIL hold_data: got v=%b d=%h required v=1 d=1fffff", bif.BD_out_valid, bif.BD_out_data);
    end
    host_word(32'h0400_0000);
    n_assert++;
    if (hold_active !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_off: got hold_active=%b required 0", hold_active);
    end
    host_word(32'h4013_3333);
    n_assert++;
    if ({bif.BD_out_valid, bif.BD_out_data} !== {1'b1, 21'h13_3333}) begin
      n_fail++;
      $display("FAIL hold_cleared: got v=%b d=%h required v=1 d=133333", bif.BD_out_valid, bif.BD_out_data);
    end
    bif.host_data  = 32'h0805_5555;
    bif.host_valid = 1'b1;
    bif.gen_data   = 21'h01_1111;
    bif.gen_valid  = 1'b1;
    #1;
    n_assert++;
    if ({bif.host_ready, bif.gen_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL hold_same_cycle_ready: got host_ready=%b gen_ready=%b required 1 1", bif.host_ready, bif.gen_ready);
    end
    cyc();
    bif.host_valid = 1'b0;
    bif.gen_data   = 21'h02_2222;
    n_assert++;
    if (bif.BD_out_data !== 21'h01_1111) begin
      n_fail++;
      $display("FAIL hold_same_cycle: got d=%h required 011111", bif.BD_out_data);
    end
    cyc();
    bif.gen_valid = 1'b0;
    n_assert++;
    if (bif.BD_out_data !== 21'h05_5555) begin
      n_fail++;
      $display("FAIL hold_next_word: got d=%h required 055555", bif.BD_out_data);
    end
    host_word(32'h0400_0000);
    cyc();
  endtask

  task automatic test_arbitration();
    logic [20:0] hw [64];
    logic [20:0] gw [64];
    int hi = 0, gi = 0, ko = 0, oh = 0, og = 0;
    logic [20:0] exp_d;
    for (int i = 0; i < 64; i++) begin
      hw[i] = {1'b0, 20'($urandom)};
      gw[i] = {1'b1, 20'($urandom)};
    end
    do_reset();
    release_resets();
    bif.BD_out_ready = 1'b1;
    bif.host_valid   = 1'b1;
    bif.gen_valid    = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bif.host_data = {11'h200, hw[hi]};
      bif.gen_data  = gw[gi];
      #1;
      if (bif.host_ready) hi++;
      if (bif.gen_ready) gi++;
      cyc();
      if (bif.BD_out_valid && ko < 24) begin
        if (((ko / 4) % 2) == 1) exp_d = gw[og++];
        else exp_d = hw[oh++];
        n_assert++;
        if (bif.BD_out_data !== exp_d) begin
          n_fail++;
          $display("FAIL arb_order: output %0d got %h required %h", ko, bif.BD_out_data, exp_d);
        end
        ko++;
      end
    end
    n_assert++;
    if (ko != 24) begin
      n_fail++;
      $display("FAIL arb_count: got %0d outputs required 24", ko);
    end
    bif.host_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bif.gen_data = gw[gi];
      exp_d = gw[gi];
      #1;
      n_assert++;
      if (bif.gen_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL arb_gen_only_ready: cycle %0d got gen_ready=%b required 1", c, bif.gen_ready);
      end
      if (bif.gen_ready) gi++;
      cyc();
      n_assert++;
      if ({bif.BD_out_valid, bif.BD_out_data} !== {1'b1, exp_d}) begin
        n_fail++;
        $display("FAIL arb_gen_only_out: got v=%b d=%h required v=1 d=%h", bif.BD_out_valid, bif.BD_out_data, exp_d);
      end
    end
    bif.gen_valid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    logic [31:0] hw[$];
    logic [20:0] gw[$];
    logic [20:0] hexp[$];
    logic [20:0] gexp[$];
    logic [20:0] p_d = '0;
    logic [20:0] e;
    logic p_hr = 1'b0, p_gr = 1'b0, p_v = 1'b0, p_r = 1'b0;
    int hi = 0, gi = 0, nout = 0, nsend = 0, stall = 0, cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(1, 0) == 0) begin
        if ($urandom_range(9, 0) == 0) begin
          hw.push_back({1'b1, 31'($urandom)});
        end else begin
          hw.push_back({11'h200, 1'b0, 20'(i)});
          hexp.push_back({1'b0, 20'(i)});
          nsend++;
        end
      end else begin
        gw.push_back({1'b1, 20'(i)});
        gexp.push_back({1'b1, 20'(i)});
        nsend++;
      end
    end
    do_reset();
    release_resets();
    while ((hi < hw.size() || gi < gw.size() || hexp.size() + gexp.size() != 0) && cycles < 40000) begin
      if (hi < hw.size()) begin
        if (!bif.host_valid) bif.host_valid = ($urandom_range(3, 0) != 0);
        bif.host_data = hw[hi];
      end else bif.host_valid = 1'b0;
      if (gi < gw.size()) begin
        if (!bif.gen_valid) bif.gen_valid = ($urandom_range(3, 0) != 0);
        bif.gen_data = gw[gi];
      end else bif.gen_valid = 1'b0;
      bif.BD_out_ready = (stall == 0);
      #1;
      p_hr = bif.host_ready;
      p_gr = bif.gen_ready;
      p_v  = bif.BD_out_valid;
      p_r  = bif.BD_out_ready;
      p_d  = bif.BD_out_data;
      cyc();
      cycles++;
      if (p_hr) hi++;
      if (p_gr) gi++;
      if (stall > 0) stall--;
      if (p_v && p_r) begin
        nout++;
        n_assert++;
        if (p_d[20] ? (gexp.size() == 0) : (hexp.size() == 0)) begin
          n_fail++;
          $display("FAIL bp_unexpected: got word %h required none pending from that source", p_d);
        end else begin
          e = p_d[20] ? gexp.pop_front() : hexp.pop_front();
          if (p_d !== e) begin
            n_fail++;
            $display("FAIL bp_order: got %h required %h", p_d, e);
          end
        end
        stall = ($urandom_range(99, 0) < 3) ? int'($urandom_range(200, 0)) : int'($urandom_range(2, 0));
      end else if (p_v) begin
        n_assert++;
        if ({bif.BD_out_valid, bif.BD_out_data} !== {1'b1, p_d}) begin
          n_fail++;
          $display("FAIL bp_stable: got v=%b d=%h required v=1 d=%h", bif.BD_out_valid, bif.BD_out_data, p_d);
        end
      end
    end
    bif.host_valid   = 1'b0;
    bif.gen_valid    = 1'b0;
    bif.BD_out_ready = 1'b1;
    n_assert++;
    if (cycles >= 40000 || nout != nsend || hexp.size() != 0 || gexp.size() != 0) begin
      n_fail++;
      $display("FAIL bp_complete: got %0d outputs in %0d cycles (%0d host %0d gen left) required %0d outputs",
               nout, cycles, hexp.size(), gexp.size(), nsend);
    end
    cyc();
    cyc();
  endtask

  task automatic test_edge();
    bif.BD_out_ready = 1'b1;
    cyc();
    cyc();
    host_word(32'h8000_0000);
    n_assert++;
    if ({bad_op, bif.BD_out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL nop_word: got bad_op=%b v=%b required 0 0", bad_op, bif.BD_out_valid);
    end
    host_word(32'h0000_0000);
    n_assert++;
    if ({bad_op, bif.BD_out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_op_pulse: got bad_op=%b v=%b required 1 0", bad_op, bif.BD_out_valid);
    end
    cyc();
    n_assert++;
    if (bad_op !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op_width: got bad_op=%b required 0", bad_op);
    end
    bif.BD_out_ready = 1'b0;
    bif.gen_data     = 21'h0B_EEF0;
    bif.gen_valid    = 1'b1;
    cyc();
    bif.gen_valid = 1'b0;
    cyc();
    n_assert++;
    if ({bif.BD_out_valid, bif.BD_out_data} !== {1'b1, 21'h0B_EEF0}) begin
      n_fail++;
      $display("FAIL pending_word: got v=%b d=%h required v=1 d=0beef0", bif.BD_out_valid, bif.BD_out_data);
    end
    reset = 1'b1;
    cyc();
    n_assert++;
    if ({bif.BD_out_valid, pReset, sReset} !== 3'b011) begin
      n_fail++;
      $display("FAIL reset_mid_transfer: got v=%b p=%b s=%b required v=0 p=1 s=1", bif.BD_out_valid, pReset, sReset);
    end
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_reset_release();
    test_gating();
    test_hold();
    test_arbitration();
    test_backpressure();
    test_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bd_downstream_ctrl.md
# bd_downstream_ctrl

Controller for the FPGA→Braindrop downstream channel. It decodes 32-bit host words from the pipe-in path, covering the nop, send, reset-release and hold-data opcodes. It arbitrates BD sends between the host stream and an internal generator stream, and drives the 21-bit BD_out valid/ready port through a single output register. It also owns the pReset/sReset sequencing and blocks all sends until both chip resets are released.

## Interface
Parameters:
- MAX_BURST, 4: maximum consecutive grants to one source while the other is requesting (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- host_data  in  32  host word; opcode in [31:26], payload in [20:0].
- host_valid  in  1  host word present.
- host_ready  out  1  host word consumed this cycle.
- gen_data  in  21  generator BD word.
- gen_valid  in  1  generator word present.
- gen_ready  out  1  generator word consumed this cycle.
- BD_out_data  out  21  word to BD.
- BD_out_valid  out  1  output register full.
- BD_out_ready  in  1  BD accepts; transfer when valid & ready at a clk edge.
- pReset  out  1  BD power-on reset, registered.
- sReset  out  1  BD system reset, registered.
- hold_active  out  1  hold override enabled.
- bad_op  out  1  one-cycle pulse when an unrecognised host word is dropped.

## Operation
- Host decode: the first matching rule applies, in priority order.
  - bit31: nop. Consumed and dropped.
  - bit30: send. Payload [20:0] is a send candidate.
  - bit29: pReset←0.
  - bit28: sReset←0.
  - bit27: hold_active←1, hold_data←[20:0].
  - bit26: hold_active←0.
  - All bits [31:26] zero: dropped, bad_op pulses.
- Non-send host words are always consumed the cycle they are valid (host_ready=1). They never touch the output register.
- Send gating:
  - While pReset|sReset is 1, host send words and generator words are not consumed. host_ready=0 for send words; gen_ready=0.
  - Config words are still accepted while gating is active.
- Load condition: load = !BD_out_valid | BD_out_ready. A source word is consumed only on a cycle where load is true and that source is granted.
- Arbitration (registers owner ∈ {host, gen} and burst_cnt):
  - If exactly one source requests, it wins.
  - If both request and owner's burst_cnt < MAX_BURST, owner wins.
  - Otherwise the other source wins.
  - On a win by the owner, burst_cnt increments, saturating at MAX_BURST. On a win by a new owner, owner updates and burst_cnt←1.
  - No request: owner and burst_cnt hold.
- Hold override: if hold_active is 1 when a word is loaded, BD_out_data←hold_data instead of the source payload. The source word is still consumed.
- Output register holds BD_out_data stable while BD_out_valid & !BD_out_ready. Words leave in grant order with no loss or duplication.

## Timing
- Reset values:
  - BD_out_valid=0, BD_out_data=0.
  - pReset=1, sReset=1.
  - hold_active=0, hold_data=0.
  - owner=host, burst_cnt=0, bad_op=0.
  - host_ready=0 and gen_ready=0 while reset is high.
- host_ready and gen_ready are combinational from valid, the decode, gating, load and arbitration state.
- Latency: word consumed at edge N → BD_out_valid=1 with its data after edge N.
- Throughput: one word per cycle while BD_out_ready is held at 1.
- Config effects are registered and visible the cycle after consumption:
  - A hold-on consumed in the same cycle as a generator word load does not affect that word.
  - A pReset-off does not ungate the same cycle.
- Reset mid-transfer clears the output register (any pending word is discarded) and reasserts pReset and sReset.
- bad_op is high for exactly the cycle after the bad word is consumed.

## Test plan
- Reset release: after reset, send 0x20000000 then 0x10000000. pReset falls one cycle after the first word is accepted, sReset one cycle after the second. BD_out_valid stays 0.
- Gating: send 0x40133333 with resets asserted → host_ready=0, no output. Then release both resets → BD_out_data=0x133333, BD_out_valid=1 one cycle after consumption.
- Hold: send 0x081FFFFF, then 0x40133333 → BD_out_data=0x1FFFFF. Then send 0x04000000 and 0x40133333 → 0x133333.
- Arbitration: MAX_BURST=4, both sources continuously valid, BD_out_ready=1 → output sequence of 4 host, 4 gen, 4 host, and so on. With only gen valid, gen wins every cycle.
- Backpressure: BD_out_ready randomly stalled for 0–200 cycles per word, as the BD sink bench does, over 1000 mixed words. Data stays stable while stalled, and the scoreboard shows every word exactly once in per-source order.
- Edge cases:
  - 0x80000000 is consumed with no output and no bad_op.
  - 0x00000000 gives a 1-cycle bad_op pulse.
  - Reset asserted while BD_out_valid=1 and BD_out_ready=0 → BD_out_valid=0, pReset=sReset=1 the next cycle.
